// File: rtl/pattern_window_sched.sv
// Multi-channel windowed pattern counter: scans each enabled channel in turn and reports its match count.
// Optional build macro SCHED_NONOVERLAP_EN: matches do not share bits (default: overlapping matches).
module pattern_window_sched #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned PAT_W = 3,
    parameter int unsigned WIN_W = 10,
    parameter int unsigned CNT_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIN_W-1:0]         win_len,
    input  logic [PAT_W-1:0]         pattern,
    input  logic [NCH-1:0]           ch_en,
    input  logic [NCH-1:0]           x,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(NCH)-1:0]   res_ch,
    output logic [CNT_W-1:0]         res_count,
    output logic                     done
);

    localparam int unsigned CH_W   = $clog2(NCH);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        RUN,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [NCH-1:0]     pend_q, pend_d;
    logic [CH_W-1:0]    sel_q, sel_d;
    logic [PAT_W-1:0]   shreg_q, shreg_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIN_W-1:0]   wcnt_q, wcnt_d;
    logic               done_q, done_d;

    logic [CH_W-1:0]    first_idx;
    logic [NCH-1:0]     first_mask;
    logic               bit_in;
    logic [PAT_W-1:0]   shreg_next;
    logic               hit;

    // Lowest pending channel wins; the descending loop leaves the smallest index last.
    always_comb begin
        first_idx  = '0;
        first_mask = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (pend_q[i-1]) begin
                first_idx  = CH_W'(i - 1);
                first_mask = '0;
                first_mask[i-1] = 1'b1;
            end
        end
    end

    always_comb begin
        bit_in     = x[sel_q];
        shreg_next = {shreg_q[PAT_W-2:0], bit_in};
        hit        = (fill_q >= FILL_W'(PAT_W - 1)) && (shreg_next == pat_q);
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        pat_d   = pat_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        shreg_d = shreg_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d  = win_len;
                    pat_d  = pattern;
                    pend_d = ch_en;
                    if ((ch_en == '0) || (win_len == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end

            SELECT: begin
                sel_d   = first_idx;
                pend_d  = pend_q & ~first_mask;
                shreg_d = '0;
                fill_d  = '0;
                cnt_d   = '0;
                wcnt_d  = '0;
                state_d = RUN;
            end

            RUN: begin
                shreg_d = shreg_next;
                if (fill_q != FILL_W'(PAT_W)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if (hit) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef SCHED_NONOVERLAP_EN
                    fill_d  = '0;
                    shreg_d = '0;
`endif
                end
                wcnt_d = wcnt_q + WIN_W'(1);
                if (wcnt_q == (win_q - WIN_W'(1))) begin
                    state_d = REPORT;
                end
            end

            REPORT: begin
                if (res_ready) begin
                    if (pend_q != '0) begin
                        state_d = SELECT;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            pat_q   <= '0;
            pend_q  <= '0;
            sel_q   <= '0;
            shreg_q <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            pat_q   <= pat_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == REPORT);
    assign res_ch    = sel_q;
    assign res_count = cnt_q;
    assign done      = done_q;

endmodule
